hilo_div_unit: RTL and testbench
================================

Name: hilo_div_unit

Overview:
- Downstream of the ALU: consumes the ALU's 64-bit multiply product ({hi, out3}) and holds the architectural HI/LO register pair.
- Also performs iterative 32-bit signed/unsigned division and handles the move-to-HI/LO operations.
- Supplies HI/LO read values to the writeback mux for mfhi/mflo.
- Stalls the pipeline through `busy` while a divide is in flight.

Parameters:
- WIDTH, 32, operand, HI and LO width.
- CNT_W, 6, iteration-counter width (must hold WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  operation request, sampled on the rising edge.
- op  input  3  0=nop, 1=load product, 2=div (signed), 3=divu, 4=mthi, 5=mtlo, 6..7=nop.
- mul_hi  input  WIDTH  ALU product upper word (ALU hi).
- mul_lo  input  WIDTH  ALU product lower word (ALU out3).
- rs_val  input  WIDTH  dividend for div/divu; source value for mthi/mtlo.
- rt_val  input  WIDTH  divisor.
- busy  output  1  divide in progress; new requests are ignored while high.
- done  output  1  one-cycle pulse when a divide completes or aborts.
- div_by_zero  output  1  one-cycle pulse coincident with `done` when the divisor was 0.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi_out, lo_out, busy, done, div_by_zero and the counter all 0.
  - Reset asserted mid-divide aborts the divide; HI/LO go to 0 and no done pulse is produced.
- An op is accepted on a rising edge only when op_valid=1 and state=IDLE (busy=0). While busy, op_valid is ignored entirely; nothing is queued.
- done and div_by_zero default to 0 every cycle unless set as below.
- op=1: hi_out<=mul_hi, lo_out<=mul_lo on the accept edge. Zero latency, busy stays 0.
- op=4: hi_out<=rs_val on the accept edge. op=5: lo_out<=rs_val on the accept edge. The other register is unchanged.
- op=2/3 with rt_val==0:
  - No divide; HI/LO unchanged; state stays IDLE.
  - done=1 and div_by_zero=1 for the one cycle following the accept edge.
- op=2/3 with rt_val!=0, FSM IDLE -> CALC -> FIX -> IDLE:
  - Accept edge T:
    - Latch the dividend and divisor magnitudes. For op=2, magnitude = two's-complement absolute value; for op=3, the raw value.
    - Latch q_neg = sign(rs) xor sign(rt) and r_neg = sign(rs); both are 0 for op=3.
    - Clear remainder and counter; state=CALC; busy=1.
  - CALC, edges T+1..T+32:
    - One restoring step per edge, MSB first: rem = {rem, dividend_msb}; if rem >= divisor, then rem -= divisor and the quotient bit = 1.
    - The counter increments each edge; after the 32nd step, state=FIX.
  - FIX, edge T+33:
    - lo_out <= q_neg ? -quot : quot.
    - hi_out <= r_neg ? -rem : rem.
    - busy=0, done=1 for one cycle, state=IDLE.
  - Latency: busy is high for 33 cycles; the result is visible and done is high in the cycle after edge T+33. A new op may be accepted on edge T+34.
- Arithmetic:
  - Truncating division: the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) wraps: lo=0x80000000, hi=0.
  - The magnitude datapath is WIDTH+1 bits internally so that |-2^31| is exact. All negation is modulo 2^WIDTH.
- HI/LO are never partially updated during CALC; hi_out/lo_out hold their pre-divide values until FIX.
- Operand inputs may change after the accept edge without effect.

Test Plan:
- Reset then op=1 with mul_hi=0x00000001, mul_lo=0xFFFFFFFE -> next cycle hi_out=0x00000001, lo_out=0xFFFFFFFE, busy=0 throughout.
- op=3 with rs=100, rt=7 at edge T -> busy high 33 cycles; done pulses once after edge T+33 with lo_out=14, hi_out=2. Holding op_valid with op=4 during busy leaves HI unchanged.
- op=2 with rs=0xFFFFFFF9 (-7), rt=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Then op=2 with rs=0x80000000, rt=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- Preload HI=0xAAAA0000, LO=0x5555 via op=4/op=5, then op=2 with rt=0 -> done=div_by_zero=1 for exactly one cycle the next cycle, busy never high, HI/LO unchanged.
- Start op=3 with rs=0xFFFFFFFF, rt=3; assert rst_n=0 at edge T+10 -> busy, done, hi_out and lo_out drop to 0 immediately. After release, op=3 with the same operands completes with lo_out=0x55555555, hi_out=0.
- Back-to-back: op=3 result done, op=1 accepted on edge T+34 -> HI/LO take the product values; no spurious done.

Source files
------------

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: architectural HI/LO register pair with product load,
// move-to-HI/LO, and an iterative restoring 32-bit signed/unsigned divider.
// Divides run IDLE -> CALC (one quotient bit per cycle) -> FIX (sign
// correction and HI/LO write), holding busy high for WIDTH+1 cycles.
module hilo_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   dvd;      // dividend magnitude, shifts out MSB-first and fills with quotient bits
    logic [WIDTH-1:0]   dvs;      // divisor magnitude
    logic [WIDTH-1:0]   rem;      // partial remainder (always < dvs, so WIDTH bits suffice)
    logic [CNT_W-1:0]   cnt;
    logic               q_neg;
    logic               r_neg;

    logic               is_signed;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     rem_sh;   // shifted remainder needs one extra bit before the compare
    logic               step_ge;
    logic [WIDTH-1:0]   rem_sub;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        is_signed = (op == OP_DIV);
        rs_mag    = rs_val;
        rt_mag    = rt_val;
        if (is_signed && rs_val[WIDTH-1]) rs_mag = -rs_val;
        if (is_signed && rt_val[WIDTH-1]) rt_mag = -rt_val;

        rem_sh  = {rem, dvd[WIDTH-1]};
        step_ge = (rem_sh >= {1'b0, dvs});
        // When step_ge holds the difference is below dvs, so modulo-2^WIDTH is exact.
        rem_sub = rem_sh[WIDTH-1:0] - dvs;
    end

    // Control FSM, divider datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so a divide aborted by reset leaves no stale state.
            state       <= IDLE;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done        <= 1'b0;
            div_by_zero <= 1'b0;

            case (state)
                IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MUL: begin
                                hi_out <= mul_hi;
                                lo_out <= mul_lo;
                            end
                            OP_MTHI: hi_out <= rs_val;
                            OP_MTLO: lo_out <= rs_val;
                            OP_DIV, OP_DIVU: begin
                                if (rt_val == '0) begin
                                    done        <= 1'b1;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    dvd   <= rs_mag;
                                    dvs   <= rt_mag;
                                    rem   <= '0;
                                    cnt   <= '0;
                                    q_neg <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                    r_neg <= is_signed & rs_val[WIDTH-1];
                                    busy  <= 1'b1;
                                    state <= CALC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                CALC: begin
                    rem <= step_ge ? rem_sub : rem_sh[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], step_ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= FIX;
                end

                FIX: begin
                    lo_out <= q_neg ? -dvd : dvd;
                    hi_out <= r_neg ? -rem : rem;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit. Divide results are predicted by a
// 64-bit reference model and pushed to a scoreboard queue at issue time; a
// monitor pops and compares each entry when done pulses.
module tb_hilo_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] mul_hi, mul_lo, rs_val, rt_val;
    logic             busy, done, div_by_zero;
    logic [WIDTH-1:0] hi_out, lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mdl_hi      = '0;
    logic [31:0] mdl_lo      = '0;

    hilo_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op          (op),
        .mul_hi      (mul_hi),
        .mul_lo      (mul_lo),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference divide in 64-bit arithmetic: truncating, remainder follows dividend.
    function automatic exp_t model_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sd, q, r;
        if (b == 32'd0) begin
            e.hi  = mdl_hi;
            e.lo  = mdl_lo;
            e.dbz = 1'b1;
        end else begin
            sa    = (o == 3'd2) ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
            sd    = (o == 3'd2) ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
            q     = sa / sd;
            r     = sa % sd;
            e.hi  = r[31:0];
            e.lo  = q[31:0];
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drive one request, let it be accepted on the next rising edge, update the model.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] mh, input logic [31:0] ml, input bit push);
        exp_t e;
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        mul_hi   = mh;
        mul_lo   = ml;
        case (o)
            3'd1: begin mdl_hi = mh; mdl_lo = ml; end
            3'd4: mdl_hi = a;
            3'd5: mdl_lo = a;
            3'd2, 3'd3: begin
                e = model_div(o, a, b);
                if (push) sb.push_back(e);
                mdl_hi = e.hi;
                mdl_lo = e.lo;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        rs_val   = $urandom;
        rt_val   = $urandom;
    endtask

    // Wait (bounded) for done; checks busy length and that HI/LO hold during the divide.
    task automatic wait_done(input string tag, input int exp_busy);
        int   busy_cycles = 0;
        bit   held_bad    = 0;
        bit   seen        = 0;
        logic [31:0] pre_hi = hi_out;
        logic [31:0] pre_lo = lo_out;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin
                busy_cycles++;
                if (hi_out !== pre_hi || lo_out !== pre_lo) held_bad = 1;
            end
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_len"}, 32'(busy_cycles), 32'(exp_busy));
        check({tag, "_hilo_held"}, 32'(held_bad), 32'd0);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_hi", hi_out, e.hi);
                    check("sb_lo", lo_out, e.lo);
                    check("sb_dbz", 32'(div_by_zero), 32'(e.dbz));
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        mul_hi   = '0;
        mul_lo   = '0;
        rs_val   = '0;
        rt_val   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Product load: zero latency, never busy.
        issue(3'd1, 32'd0, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        check("mul_busy", 32'(busy), 32'd0);
        check("mul_hi", hi_out, mdl_hi);
        check("mul_lo", lo_out, mdl_lo);

        // divu 100/7 with an mthi held on the inputs throughout busy.
        issue(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 1);
        op_valid = 1'b1;
        op       = 3'd4;
        rs_val   = 32'hDEAD_BEEF;
        wait_done("divu_100_7", 33);
        op_valid = 1'b0;
        @(negedge clk);
        check("divu_done_once", 32'(done), 32'd0);
        check("mthi_ignored", hi_out, mdl_hi);

        // Signed divides, including the overflow case.
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1);
        wait_done("div_m7_2", 33);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1);
        wait_done("div_ovf", 33);
        issue(3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'd0, 32'd0, 1);
        wait_done("div_pos_neg", 33);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1);
        wait_done("divu_max", 33);

        // Divide by zero: single-cycle pulse, never busy, HI/LO untouched.
        issue(3'd4, 32'hAAAA_0000, 32'd0, 32'd0, 32'd0, 0);
        issue(3'd5, 32'h0000_5555, 32'd0, 32'd0, 32'd0, 0);
        check("mt_hi", hi_out, mdl_hi);
        check("mt_lo", lo_out, mdl_lo);
        issue(3'd2, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1);
        @(negedge clk);
        check("dbz_busy", 32'(busy), 32'd0);
        check("dbz_done", 32'(done), 32'd1);
        check("dbz_flag", 32'(div_by_zero), 32'd1);
        @(negedge clk);
        check("dbz_done_clr", 32'(done), 32'd0);
        check("dbz_flag_clr", 32'(div_by_zero), 32'd0);
        check("dbz_hi_keep", hi_out, 32'hAAAA_0000);

        // Reset in the middle of a divide aborts it with no done pulse.
        issue(3'd3, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        mdl_hi = '0;
        mdl_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(3'd3, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1);
        wait_done("divu_after_rst", 33);

        // Back-to-back: product load accepted on the first edge after done.
        issue(3'd3, 32'd1000, 32'd33, 32'd0, 32'd0, 1);
        wait_done("divu_b2b", 33);
        issue(3'd1, 32'd0, 32'd0, 32'hCAFE_0001, 32'h0BAD_F00D, 0);
        check("b2b_hi", hi_out, 32'hCAFE_0001);
        check("b2b_lo", lo_out, 32'h0BAD_F00D);
        @(negedge clk);
        check("b2b_no_done", 32'(done), 32'd0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
